grid_server: RTL
================

# grid_server

Map-store responder for grid-cell lookups. Holds the 64×32 level map as 3-bit cell codes and serves read requests from two clients: client 0 is the player updater (collision check), client 1 is the raycaster (wall hits). A fair request/acknowledge handshake serializes the two clients. A single-cycle write port lets the level loader fill or edit the map.

## Interface
Parameters:
- `CELL_W`, default 3: cell code width (0 = empty, nonzero = solid/typed block).
- `X_W`, default 6: grid x width (64 columns).
- `Y_W`, default 5: grid y width (32 rows).

Ports:
- `clock`, input, 1: single system clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req_0`, input, 1: client 0 lookup request. Held high until `ack_0`.
- `grid_x_0`, input, X_W: client 0 column. Stable while `req_0` is high.
- `grid_y_0`, input, Y_W: client 0 row. Stable while `req_0` is high.
- `req_1`, `grid_x_1`, `grid_y_1`: client 1 equivalents of the three client 0 ports.
- `ack_0`, output, 1: one-cycle pulse; `grid_out` holds client 0's result.
- `ack_1`, output, 1: one-cycle pulse; `grid_out` holds client 1's result.
- `grid_out`, output, CELL_W: lookup result. Valid only while an ack is high.
- `busy`, output, 1: high in READ and RESP.
- `wr_en`, input, 1: write strobe from the level loader.
- `wr_x`, input, X_W: write column.
- `wr_y`, input, Y_W: write row.
- `wr_data`, input, CELL_W: value written.

## Operation
- Storage: 2048 × CELL_W synchronous RAM, addressed `{y, x}` (y in the high bits).
- Three-state FSM: IDLE, READ, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that client.
  - Both requests: grant the client that was not granted last (`last_grant`).
  - On a grant: latch the client id into `owner`, present that client's `{y, x}` to the RAM read address, update `last_grant`, go to READ.
- READ: RAM output registers. Go to RESP.
- RESP:
  - `grid_out` = registered RAM data.
  - Assert `ack_<owner>`; the other ack stays low.
  - Go to IDLE.
- Request rules:
  - A client drops `req` on the edge that ends its ack cycle.
  - A `req` still high in the following IDLE cycle counts as a new request.
  - A request that is not granted waits; it is never dropped by the server.
- Writes:
  - Accepted in every state. The RAM location is updated on the edge where `wr_en` is sampled high.
  - Read-first: a read address presented on the same edge as a write to that address returns the old value.
  - A write arriving on any later edge is visible to the next lookup.
- Reset:
  - Applies from any state: FSM goes to IDLE, in-flight lookup aborted with no ack.
  - `last_grant` = 1, so client 0 wins the first tie.
  - RAM contents are not cleared.
- Output reset values: `ack_0` = 0, `ack_1` = 0, `busy` = 0, `grid_out` = 0.
- Address wrap: none is possible. X_W and Y_W fully cover the grid, so every input coordinate addresses a real cell.

## Timing
- Lookup latency:
  - `req` first sampled high in IDLE at edge n.
  - READ during cycle n+1.
  - Ack and `grid_out` valid during cycle n+2.
  - Back in IDLE at cycle n+3.
- Throughput: one lookup per 3 cycles.
- Starvation bound: with both clients requesting continuously, grants alternate 0,1,0,1. Neither client waits more than 3 cycles beyond its own 3-cycle lookup.
- `grid_out` and the acks are registered outputs. No combinational path from any input to any output.
- `busy` is high exactly in READ and RESP.

## Configuration
- Macro: `GRID_BORDER_WALL_EN`.
- Defined: any lookup where x = 0, x = 63, y = 0 or y = 31 returns 3'b001 regardless of RAM contents. Writes to those cells still update the RAM. The player can never leave the map even if the loaded level is open at its edges.
- Undefined: border cells return their stored RAM value like any other cell.
- Latency and handshake are identical in both builds.

## Test plan
- Fill, then lookup: write 3'b101 to (10,7) and 0 to (11,7); client 0 requests (10,7), then (11,7). Required: `ack_0` 2 cycles after each request is sampled, `grid_out` = 5 then 0; `ack_1` never asserts.
- Contention: `req_0` and `req_1` rise on the same cycle after reset and stay high. Required: ack order is 0, 1, 0, 1; each ack is a single-cycle pulse spaced 3 cycles apart.
- Read-first collision: write 3'b010 to (20,3), then write 3'b111 to (20,3) on the same edge as a client 1 grant for (20,3). Required: `grid_out` = 2; a follow-up lookup returns 7.
- Reset mid-lookup: assert `reset` during READ. Required: no ack, `busy` = 0 and `grid_out` = 0 on the next cycle. A new request afterwards completes normally, and the RAM still holds its pre-reset contents.
- Border with the macro defined: write 0 to (0,15) and (63,31). Required: lookups return 1. With the macro undefined: the same lookups return 0.
- Held request: client 0 keeps `req_0` high through the ack cycle. Required: a second `ack_0` arrives 3 cycles after the first, with no spurious ack.

Source files
------------

// File: rtl/grid_server_if.sv
// grid_server_if: lookup and write bundle between the two clients,
// the level loader and the grid_server map store.
interface grid_server_if #(
   parameter int CELL_W = 3,
   parameter int X_W    = 6,
   parameter int Y_W    = 5
);
   logic              req_0;
   logic [X_W-1:0]    grid_x_0;
   logic [Y_W-1:0]    grid_y_0;
   logic              req_1;
   logic [X_W-1:0]    grid_x_1;
   logic [Y_W-1:0]    grid_y_1;
   logic              ack_0;
   logic              ack_1;
   logic [CELL_W-1:0] grid_out;
   logic              busy;
   logic              wr_en;
   logic [X_W-1:0]    wr_x;
   logic [Y_W-1:0]    wr_y;
   logic [CELL_W-1:0] wr_data;

   modport master (
      output req_0, grid_x_0, grid_y_0,
      output req_1, grid_x_1, grid_y_1,
      output wr_en, wr_x, wr_y, wr_data,
      input  ack_0, ack_1, grid_out, busy
   );

   modport slave (
      input  req_0, grid_x_0, grid_y_0,
      input  req_1, grid_x_1, grid_y_1,
      input  wr_en, wr_x, wr_y, wr_data,
      output ack_0, ack_1, grid_out, busy
   );
endinterface

// File: rtl/grid_server.sv
// grid_server: 64x32 level map store serving two fair-arbitrated clients.
// Optional macro GRID_BORDER_WALL_EN forces border lookups to return 1.
module grid_server #(
   parameter int CELL_W = 3,
   parameter int X_W    = 6,
   parameter int Y_W    = 5
) (
   input logic         clock,
   input logic         reset,
   grid_server_if.slave bus
);
   localparam int AW    = X_W + Y_W;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   state_t            state;
   state_t            state_nx;
   logic [CELL_W-1:0] mem [DEPTH];
   logic [CELL_W-1:0] ram_q;
   logic [CELL_W-1:0] rd_data;
   logic [CELL_W-1:0] grid_q;
   logic              ack_0_q;
   logic              ack_1_q;
   logic              owner;
   logic              last_grant;
   logic              grant;
   logic              grant_id;
   logic [X_W-1:0]    sel_x;
   logic [Y_W-1:0]    sel_y;
   logic [AW-1:0]     rd_addr;
   logic [AW-1:0]     wr_addr;

   assign sel_x   = grant_id ? bus.grid_x_1 : bus.grid_x_0;
   assign sel_y   = grant_id ? bus.grid_y_1 : bus.grid_y_0;
   assign rd_addr = {sel_y, sel_x};
   assign wr_addr = {bus.wr_y, bus.wr_x};

   // Arbitration and next state; on a tie the client not served last wins
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      grant_id = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req_0 && bus.req_1) begin
               grant    = 1'b1;
               grant_id = ~last_grant;
            end else if (bus.req_0) begin
               grant    = 1'b1;
               grant_id = 1'b0;
            end else if (bus.req_1) begin
               grant    = 1'b1;
               grant_id = 1'b1;
            end
            if (grant) state_nx = READ;
         end
         READ:    state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Remember who holds the current lookup and who was served last
   always_ff @(posedge clock) begin
      if (reset) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (grant) begin
         owner      <= grant_id;
         last_grant <= grant_id;
      end
   end

   // Loader writes, accepted in every state
   always_ff @(posedge clock) begin
      if (bus.wr_en) mem[wr_addr] <= bus.wr_data;
   end

   // Read on the grant edge; a same-edge write is not yet visible
   always_ff @(posedge clock) begin
      if (grant) ram_q <= mem[rd_addr];
   end

`ifdef GRID_BORDER_WALL_EN
   logic border;
   logic border_q;

   assign border = (sel_x == '0) || (sel_x == {X_W{1'b1}}) ||
                   (sel_y == '0) || (sel_y == {Y_W{1'b1}});

   // Border flag travels alongside the RAM read
   always_ff @(posedge clock) begin
      if (grant) border_q <= border;
   end

   assign rd_data = border_q ? CELL_W'(1) : ram_q;
`else
   assign rd_data = ram_q;
`endif

   // Registered response: ack to the owner with its cell code
   always_ff @(posedge clock) begin
      if (reset) begin
         ack_0_q <= 1'b0;
         ack_1_q <= 1'b0;
         grid_q  <= '0;
      end else begin
         ack_0_q <= (state == READ) && !owner;
         ack_1_q <= (state == READ) && owner;
         grid_q  <= (state == READ) ? rd_data : '0;
      end
   end

   assign bus.ack_0    = ack_0_q;
   assign bus.ack_1    = ack_1_q;
   assign bus.grid_out = grid_q;
   assign bus.busy     = (state == READ) || (state == RESP);
endmodule
